// File: rtl/tohost_status_monitor.sv
// Snoops MMIO writes for the RISC-V tohost/fromhost convention and drives the pass/fail/syscall status.
// Optional inactivity watchdog is compiled in with `define TOHOST_WATCHDOG_EN.
module tohost_status_monitor #(
   parameter int                DATA_W          = 64,
   parameter int                ADDR_W          = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR     = 'h8000_1000,
   parameter logic [ADDR_W-1:0] FROMHOST_ADDR   = 'h8000_1040,
   parameter int unsigned       WATCHDOG_CYCLES = 1000000
) (
   input  logic              core_clock,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              syscall_valid,
   output logic [DATA_W-1:0] syscall_data,
   input  logic              syscall_ack,
   input  logic [DATA_W-1:0] syscall_resp,
   output logic [DATA_W-1:0] fromhost,
   output logic              fromhost_valid,
   output logic              success,
   output logic              failure,
   output logic [DATA_W-2:0] exit_code,
   output logic [63:0]       cycle_count
);

   typedef enum logic [1:0] {RUN, SYSCALL, DONE_PASS, DONE_FAIL} state_t;

   state_t state, state_next;
   logic   tohost_hit, fromhost_hit;
   logic   data_one, data_zero;
   logic   wd_fire;

   function automatic logic [63:0] sat_inc(input logic [63:0] v);
      return (&v) ? v : v + 64'd1;
   endfunction

   // Only RUN consumes writes; DONE states accept and drop them so the bus never stalls.
   assign tohost_hit   = wr_valid && (state == RUN) && (wr_addr == TOHOST_ADDR);
   assign fromhost_hit = wr_valid && (state == RUN) && (wr_addr == FROMHOST_ADDR);
   assign data_one     = (wr_data == DATA_W'(1));
   assign data_zero    = (wr_data == '0);

`ifdef TOHOST_WATCHDOG_EN
   logic [31:0] wd_count;

   // Fires on the edge at which the RUN-cycle count would reach the limit.
   assign wd_fire = (state == RUN) && (wd_count == 32'(WATCHDOG_CYCLES - 1));

   always_ff @(posedge core_clock) begin
      if (!reset)
         wd_count <= '0;
      else if (state == RUN)
         wd_count <= tohost_hit ? '0 : wd_count + 32'd1;
   end
`else
   // Limit is only meaningful with the watchdog compiled in.
   assign wd_fire = 1'b0 & (WATCHDOG_CYCLES == 0);
`endif

   always_ff @(posedge core_clock) begin
      if (!reset)
         state <= RUN;
      else
         state <= state_next;
   end

   always_comb begin
      state_next    = state;
      wr_ready      = 1'b1;
      syscall_valid = 1'b0;
      success       = 1'b0;
      failure       = 1'b0;
      case (state)
         RUN: begin
            if (tohost_hit) begin
               if (data_one)
                  state_next = DONE_PASS;
               else if (wr_data[0])
                  state_next = DONE_FAIL;
               else if (!data_zero)
                  state_next = SYSCALL;
            end else if (wd_fire) begin
               state_next = DONE_FAIL;
            end
         end
         SYSCALL: begin
            wr_ready      = 1'b0;
            syscall_valid = 1'b1;
            if (syscall_ack)
               state_next = RUN;
         end
         DONE_PASS: success = 1'b1;
         DONE_FAIL: failure = 1'b1;
         default:   state_next = RUN;
      endcase
   end

   always_ff @(posedge core_clock) begin
      if (!reset) begin
         syscall_data   <= '0;
         fromhost       <= '0;
         fromhost_valid <= 1'b0;
         exit_code      <= '0;
         cycle_count    <= '0;
      end else begin
         fromhost_valid <= 1'b0;
         if (state == RUN || state == SYSCALL)
            cycle_count <= sat_inc(cycle_count);
         if (state == RUN) begin
            if (state_next == DONE_FAIL)
               exit_code <= tohost_hit ? wr_data[DATA_W-1:1] : '1;
            if (state_next == SYSCALL)
               syscall_data <= wr_data;
            if (fromhost_hit)
               fromhost <= wr_data;
         end
         if (state == SYSCALL && syscall_ack) begin
            fromhost       <= syscall_resp;
            fromhost_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tohost_status_monitor.sv
// Directed bench for tohost_status_monitor (default build, watchdog not compiled in).
module tb_tohost_status_monitor;

   localparam logic [31:0] TOHOST   = 32'h8000_1000;
   localparam logic [31:0] FROMHOST = 32'h8000_1040;

   logic        core_clock = 1'b0;
   logic        reset;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_addr;
   logic [63:0] wr_data;
   logic        syscall_valid;
   logic [63:0] syscall_data;
   logic        syscall_ack;
   logic [63:0] syscall_resp;
   logic [63:0] fromhost;
   logic        fromhost_valid;
   logic        success;
   logic        failure;
   logic [62:0] exit_code;
   logic [63:0] cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   tohost_status_monitor dut (
      .core_clock     (core_clock),
      .reset          (reset),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .syscall_valid  (syscall_valid),
      .syscall_data   (syscall_data),
      .syscall_ack    (syscall_ack),
      .syscall_resp   (syscall_resp),
      .fromhost       (fromhost),
      .fromhost_valid (fromhost_valid),
      .success        (success),
      .failure        (failure),
      .exit_code      (exit_code),
      .cycle_count    (cycle_count)
   );

   always #5 core_clock = ~core_clock;

   task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge core_clock);
         #1;
      end
   endtask

   task automatic write(input logic [31:0] addr, input logic [63:0] data);
      wr_valid = 1'b1;
      wr_addr  = addr;
      wr_data  = data;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset        = 1'b0;
      wr_valid     = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      syscall_ack  = 1'b0;
      syscall_resp = '0;
      tick(2);
      check_eq("rst_success", success, 0);
      check_eq("rst_failure", failure, 0);
      check_eq("rst_wr_ready", wr_ready, 1);
      check_eq("rst_syscall_valid", syscall_valid, 0);
      check_eq("rst_cycle_count", cycle_count, 0);
      check_eq("rst_fromhost", fromhost, 0);
      check_eq("rst_exit_code", exit_code, 0);
      reset = 1'b1;

      // Pass after 10 idle cycles; counter includes the accepting edge, then freezes.
      tick(10);
      check_eq("run_cycle_count", cycle_count, 10);
      write(TOHOST, 64'd1);
      check_eq("pass_success", success, 1);
      check_eq("pass_failure", failure, 0);
      check_eq("pass_cycle_count", cycle_count, 11);
      write(TOHOST, 64'd7);
      tick(3);
      check_eq("pass_sticky", success, 1);
      check_eq("pass_drop_fail", failure, 0);
      check_eq("pass_count_frozen", cycle_count, 11);
      check_eq("pass_wr_ready", wr_ready, 1);

      // Failure with exit code, later pass write is dropped.
      do_reset();
      check_eq("rst2_success", success, 0);
      write(TOHOST, 64'd7);
      check_eq("fail_failure", failure, 1);
      check_eq("fail_exit_code", exit_code, 3);
      check_eq("fail_success", success, 0);
      write(TOHOST, 64'd1);
      check_eq("fail_no_pass", success, 0);
      check_eq("fail_sticky", failure, 1);
      check_eq("fail_exit_frozen", exit_code, 3);

      // Reset out of DONE_FAIL.
      do_reset();
      check_eq("rstfail_failure", failure, 0);
      check_eq("rstfail_exit_code", exit_code, 0);
      check_eq("rstfail_cycle_count", cycle_count, 0);

      // Syscall handshake; a tohost pass write held during the stall must not land.
      write(TOHOST, 64'h8000_0000_0000_0010);
      check_eq("sys_valid", syscall_valid, 1);
      check_eq("sys_wr_ready", wr_ready, 0);
      check_eq("sys_data", syscall_data, 64'h8000_0000_0000_0010);
      wr_valid = 1'b1;
      wr_addr  = TOHOST;
      wr_data  = 64'd1;
      tick(20);
      wr_valid = 1'b0;
      check_eq("sys_pending", syscall_valid, 1);
      check_eq("sys_data_held", syscall_data, 64'h8000_0000_0000_0010);
      check_eq("sys_no_success", success, 0);
      syscall_ack  = 1'b1;
      syscall_resp = 64'h1;
      tick();
      syscall_ack  = 1'b0;
      check_eq("ack_fromhost", fromhost, 1);
      check_eq("ack_fh_valid", fromhost_valid, 1);
      check_eq("ack_sys_valid", syscall_valid, 0);
      check_eq("ack_wr_ready", wr_ready, 1);
      tick();
      check_eq("ack_fh_pulse_end", fromhost_valid, 0);

      // Ack outside SYSCALL is ignored.
      syscall_ack  = 1'b1;
      syscall_resp = 64'h5;
      tick();
      syscall_ack  = 1'b0;
      check_eq("stray_ack_fromhost", fromhost, 1);
      check_eq("stray_ack_fh_valid", fromhost_valid, 0);

      // Target clears fromhost; unrelated and zero writes change nothing.
      write(FROMHOST, 64'd0);
      check_eq("fh_clear", fromhost, 0);
      check_eq("fh_clear_no_pulse", fromhost_valid, 0);
      write(32'h8000_2000, 64'd1);
      write(32'h8000_1001, 64'd1);
      write(TOHOST, 64'd0);
      check_eq("ign_success", success, 0);
      check_eq("ign_failure", failure, 0);
      check_eq("ign_syscall", syscall_valid, 0);
      check_eq("ign_wr_ready", wr_ready, 1);

      // Reset in the middle of a syscall.
      write(TOHOST, 64'd2);
      check_eq("sys2_valid", syscall_valid, 1);
      check_eq("sys2_data", syscall_data, 2);
      do_reset();
      check_eq("rstsys_valid", syscall_valid, 0);
      check_eq("rstsys_data", syscall_data, 0);
      check_eq("rstsys_wr_ready", wr_ready, 1);
      check_eq("rstsys_cycle_count", cycle_count, 0);

      // Largest odd value: exit code is all 63 upper bits.
      write(TOHOST, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("maxfail_failure", failure, 1);
      check_eq("maxfail_exit_code", exit_code, 64'h7FFF_FFFF_FFFF_FFFF);
      check_eq("maxfail_success", success, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
